fifo_word_packer: RTL

Read-side consumer for the 16-deep byte FIFO: drains bytes via the FIFO's `rd`/`data_out`/`empty` handshake and packs them little-endian into `NBYTES`-wide words on a valid/ready master port. A `flush` input forces out a partially filled word with a byte-enable mask. The block sits directly downstream of the FIFO, shares its clock and reset, and feeds any word-wide sink.

---
 rtl/fifo_word_packer.sv | 106 ++++++++++
 1 files changed

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains bytes from a 16-deep byte FIFO and packs them
// little-endian into NBYTES-wide words on a valid/ready master port. A flush
// pulse forces out a partially filled word with a byte-enable mask.
module fifo_word_packer #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifo_empty,
  input  logic                fifo_full,
  input  logic                fifo_wr,
  input  logic [7:0]          fifo_dout,
  output logic                fifo_rd,
  input  logic                flush,
  output logic [8*NBYTES-1:0] m_data,
  output logic [NBYTES-1:0]   m_keep,
  output logic                m_last,
  output logic                m_valid,
  input  logic                m_ready
);

  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [CW:0]   FULL_CNT  = (CW + 1)'(NBYTES);
  localparam logic [CW-1:0] LAST_LANE = CW'(NBYTES - 1);

  // Lanes filled so far, read-in-flight marker, and sticky flush request.
  logic [CW-1:0] cnt;
  logic          pend;
  logic          flush_req;

  logic [CW:0]   fill;
  logic          accept;
  logic          flush_fire;

  // Bytes already owned by this block: captured lanes plus the one in flight.
  assign fill = {1'b0, cnt} + {{CW{1'b0}}, pend};

  // Output handshake: a word is transferred on every rising edge where
  // m_valid and m_ready are both high. Once m_valid rises, m_data, m_keep and
  // m_last stay frozen until that transfer; m_valid never drops without it.
  // The FIFO side is the mirror image: fifo_rd is a request, and it only
  // counts as a read on an edge where the FIFO is not also writing, because
  // the FIFO services its write port first and silently drops the read.
  assign fifo_rd = !rst && !fifo_empty && !m_valid && !flush_req && (fill < FULL_CNT);
  assign accept  = fifo_rd && !(fifo_wr && !fifo_full);

  // A flush resolves only once nothing is in flight and the port is free.
  assign flush_fire = flush_req && !pend && !m_valid;

  // Capture, word completion, flush emission and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      pend      <= 1'b0;
      flush_req <= 1'b0;
      m_data    <= '0;
      m_keep    <= '0;
      m_last    <= 1'b0;
      m_valid   <= 1'b0;
    end else begin
      pend <= accept;

      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_data  <= '0;
        m_keep  <= '0;
        m_last  <= 1'b0;
      end

      if (pend) begin
        for (int k = 0; k < NBYTES; k++) begin
          if (cnt == CW'(k)) begin
            m_data[8*k +: 8] <= fifo_dout;
          end
        end
        if (cnt == LAST_LANE) begin
          // A full word always wins over a coincident flush; the flush then
          // finds cnt == 0 and retires without a second word.
          m_valid <= 1'b1;
          m_keep  <= '1;
          m_last  <= 1'b0;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else if (flush_fire) begin
        if (cnt != '0) begin
          m_valid <= 1'b1;
          for (int k = 0; k < NBYTES; k++) begin
            m_keep[k] <= (CW'(k) < cnt);
          end
          m_last  <= 1'b1;
          cnt     <= '0;
        end
      end

      // A pulse seen while a request is already outstanding is absorbed.
      if (flush_fire) begin
        flush_req <= 1'b0;
      end else if (flush) begin
        flush_req <= 1'b1;
      end
    end
  end

endmodule
